rx_ctrl: RTL and testbench

RX_CTRL -- requirements
Module: rx_ctrl

---
 rtl/rx_ctrl.sv | 67 ++++++
 tb/tb_rx_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl.sv
// rx_ctrl: UART receive handshake FSM feeding a byte FIFO with overflow and parity-error tracking.
// Define RX_CTRL_PARITY_DROP_EN to discard parity-error bytes instead of queuing them.
module rx_ctrl #(
    parameter int DEPTH = 8,
    parameter int ERRW = 8
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    Receive,
    input  logic                    parityErr,
    input  logic [7:0]              Din,
    output logic                    Received,
    output logic [7:0]              Dout,
    output logic                    Valid,
    input  logic                    Ready,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Overflow,
    output logic [ERRW-1:0]         ErrCount,
    input  logic                    Clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {WAIT, ACK} state_t;
    state_t state, state_nxt;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic capture, push_req, pop, full, push, ovf_evt, err_hit;
    always_ff @(posedge clk)
        state <= Reset ? WAIT : state_nxt;
    always_comb begin
        state_nxt = Receive ? ACK : WAIT;
        capture = (state == WAIT) && Receive;
    end
    assign Received = (state == ACK);
`ifdef RX_CTRL_PARITY_DROP_EN
    assign push_req = capture && !parityErr;
`else
    assign push_req = capture;
`endif
    assign Valid   = (Count != '0);
    assign full    = (Count == CW'(DEPTH));
    assign pop     = Valid && Ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push    = push_req && (!full || pop);
    assign ovf_evt = push_req && full && !pop;
    assign err_hit = capture && parityErr;
    assign Dout    = Valid ? mem[rd_ptr] : 8'h00;
    always_ff @(posedge clk)
        if (push && !Reset)
            mem[wr_ptr] <= Din;
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
            ErrCount <= '0;
        end else begin
            wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            Count    <= Count + CW'(push) - CW'(pop);
            Overflow <= ovf_evt || (Overflow && !Clear);
            ErrCount <= err_hit ? (Clear ? ERRW'(1) : (&ErrCount ? ErrCount : ErrCount + ERRW'(1)))
                                : (Clear ? '0 : ErrCount);
        end
    end
endmodule

// File: tb/tb_rx_ctrl.sv
// tb_rx_ctrl: randomized scoreboard bench for rx_ctrl against a queue-based reference model.
module tb_rx_ctrl;
    localparam int DEPTH = 8;
    localparam int ERRW = 8;
`ifdef RX_CTRL_PARITY_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif
    logic clk = 0, Reset = 1, Receive = 0, parityErr = 0, Ready = 0, Clear = 0;
    logic [7:0] Din = 0;
    logic Received, Valid, Overflow;
    logic [7:0] Dout;
    logic [3:0] Count;
    logic [ERRW-1:0] ErrCount;
    int checks = 0, failures = 0;
    int rdy_mode = 0;
    bit rand_clr = 0, mon_en = 0;
    byte unsigned exp_q[$];
    bit m_ack = 0, m_ov = 0, cap_m, ovf_m;
    int m_ec = 0;

    rx_ctrl #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk(clk), .Reset(Reset), .Receive(Receive), .parityErr(parityErr), .Din(Din),
        .Received(Received), .Dout(Dout), .Valid(Valid), .Ready(Ready), .Count(Count),
        .Overflow(Overflow), .ErrCount(ErrCount), .Clear(Clear)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus one "acknowledged" flag per Receive assertion.
    always @(posedge clk) begin
        if (Reset) begin
            exp_q.delete();
            m_ack = 0;
            m_ov = 0;
            m_ec = 0;
        end else begin
            cap_m = Receive && !m_ack;
            ovf_m = 0;
            if (cap_m && !(DROP && parityErr)) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(Din);
                else ovf_m = 1;
            end
            if (ovf_m) m_ov = 1;
            else if (Clear) m_ov = 0;
            if (cap_m && parityErr) m_ec = Clear ? 1 : (m_ec < 2**ERRW - 1 ? m_ec + 1 : m_ec);
            else if (Clear) m_ec = 0;
            m_ack = Receive;
        end
    end

    always @(negedge clk) if (mon_en) begin
        chk("valid", Valid, exp_q.size() != 0);
        chk("count", Count, exp_q.size());
        chk("received", Received, m_ack);
        chk("overflow", Overflow, m_ov);
        chk("errcount", ErrCount, m_ec);
        if (exp_q.size() != 0) begin
            chk("dout", Dout, exp_q[0]);
            if (Ready) void'(exp_q.pop_front());
        end else
            chk("dout_empty", Dout, 0);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            Clear = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
            Ready = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
        end
    endtask

    task automatic send(logic [7:0] d, logic p, int hold, int gap);
        Din = d;
        parityErr = p;
        Receive = 1;
        tick(hold);
        Receive = 0;
        tick(gap);
    endtask

    task automatic rst();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    initial begin
        tick(2);
        Reset = 0;
        mon_en = 1;
        send(8'hA5, 0, 3, 2);
        @(negedge clk);
        chk("a5_count", Count, 1);
        chk("a5_dout", Dout, 8'hA5);
        rst();
        for (int i = 1; i <= 9; i++) send(8'(i), 0, 1, 1);
        @(negedge clk);
        chk("fill_count", Count, 8);
        chk("fill_overflow", Overflow, 1);
        rdy_mode = 1;
        tick(10);
        rdy_mode = 0;
        tick();
        @(negedge clk);
        chk("drain_valid", Valid, 0);
        chk("drain_dout", Dout, 0);
        Clear = 1;
        tick();
        for (int i = 0; i < 8; i++) send(8'($urandom), 0, 1, 1);
        Din = 8'h55;
        parityErr = 0;
        Receive = 1;
        Ready = 1;
        tick();
        Receive = 0;
        tick();
        @(negedge clk);
        chk("full_pop_count", Count, 8);
        chk("full_pop_overflow", Overflow, 0);
        rdy_mode = 1;
        tick(10);
        for (int i = 0; i < 260; i++) send(8'($urandom), 1, 1, 1);
        @(negedge clk);
        chk("err_sat", ErrCount, 255);
        Clear = 1;
        tick();
        @(negedge clk);
        chk("clear_err", ErrCount, 0);
        chk("clear_ovf", Overflow, 0);
        rdy_mode = 0;
        rst();
        send(8'h3C, 1, 1, 1);
        @(negedge clk);
        chk("par_errcount", ErrCount, 1);
        chk("par_count", Count, DROP ? 0 : 1);
        if (!DROP) chk("par_dout", Dout, 8'h3C);
        rst();
        send(8'h11, 0, 1, 1);
        send(8'h22, 0, 1, 1);
        Din = 8'h33;
        Receive = 1;
        tick(2);
        @(negedge clk);
        chk("ack_count", Count, 3);
        Reset = 1;
        Receive = 0;
        tick();
        Reset = 0;
        @(negedge clk);
        chk("rst_count", Count, 0);
        chk("rst_received", Received, 0);
        chk("rst_valid", Valid, 0);
        send(8'h77, 0, 2, 1);
        @(negedge clk);
        chk("post_rst_dout", Dout, 8'h77);
        rdy_mode = 2;
        rand_clr = 1;
        for (int i = 0; i < 300; i++)
            send(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(1, 4), $urandom_range(1, 2));
        rand_clr = 0;
        rdy_mode = 1;
        tick(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
